obstacle_engine: RTL and testbench
==================================

# obstacle_engine

Parametrised multi-lane obstacle (car) engine for the Frogger-style VGA game. It holds the horizontal position of one car per lane and advances every lane once per video frame, with per-lane direction, per-lane period and a level-dependent speed-up. After each update it checks the player against every lane and reports a hit. It sits between the VGA timing block (frame tick source), the player controller (hit consumer) and colour generation (position consumer).

## Interface
- N_LANES, 8: number of lanes / cars (1..16)
- H_RES, 640: horizontal wrap modulus in pixels
- CAR_W, 32: car width in pixels
- PLAYER_W, 32: player width in pixels
- LANE_Y0, 64: y of lane 0 top edge
- LANE_H, 32: lane pitch in pixels
- STEP, 2: pixels moved per lane step (1..CAR_W)
- DIR_MASK, 8'b1010_1010: bit i = 1 means lane i moves right, 0 means left
- BASE_PER, 32'h1234_4321: 4-bit field per lane (lanes 0..7), frames per step; value 0 treated as 1
- X_SPACING, 80: reset x of lane i = (i*X_SPACING) mod H_RES
- CLK  in  1  system clock (25 MHz)
- RST_N  in  1  asynchronous active-low reset
- frame_tick  in  1  single-cycle pulse, once per frame (start of vblank)
- restart  in  1  synchronous; reload reset state
- enable  in  1  1 = cars move; 0 = positions frozen, collision still evaluated
- level  in  3  speed level 0..7
- player_x  in  10  player left edge
- player_y  in  10  player top edge
- car_x  out  10*N_LANES  packed car left edges, lane i at [10i+9:10i]
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at end of sweep
- hit  out  1  registered collision result, valid from done, held until next done
- overrun  out  1  sticky: frame_tick arrived while busy

## Operation
- FSM states IDLE, UPDATE, COLLIDE. IDLE -> UPDATE on frame_tick. UPDATE walks lane index 0..N_LANES-1, one lane per cycle -> COLLIDE. COLLIDE walks 0..N_LANES-1, one lane per cycle -> IDLE, pulsing done.
- UPDATE, lane i: per-lane frame counter cnt_i (4 bit) increments. Effective period = max(1, BASE_PER_i - level). When cnt_i+1 >= period, cnt_i clears and, if enable, car_x_i steps; otherwise cnt_i increments. When enable = 0, cnt_i holds.
- Step right: s = x + STEP (11 bit); x' = s >= H_RES ? s - H_RES : s. Step left: x' = x < STEP ? x + H_RES - STEP : x - STEP. Result always in 0..H_RES-1.
- COLLIDE, lane i: lane hit when player_y == LANE_Y0 + i*LANE_H and either (player_x - car_x_i) mod H_RES < CAR_W or (car_x_i - player_x) mod H_RES < PLAYER_W. Modular differences use 11-bit arithmetic with conditional +H_RES. An accumulator ORs the lane hits and clears at sweep start. hit <= accumulator on the done cycle.
- player_x/player_y are sampled per lane during COLLIDE. They are not latched, so callers hold them stable during the sweep.
- frame_tick while busy is ignored and sets overrun.
- restart has priority over everything. car_x_i returns to its reset value, cnt_i clears, the FSM goes to IDLE and overrun clears. hit holds its value. A sweep in progress is aborted with no done pulse.
- Reset (RST_N low): car_x_i = (i*X_SPACING) mod H_RES, cnt_i = 0, FSM IDLE, busy 0, done 0, hit 0, overrun 0.

## Timing
- frame_tick at cycle t: busy = 1 from t+1. Lane i is updated at the edge ending cycle t+1+i. Lane i is checked at cycle t+1+N_LANES+i. done and the new hit are visible at t+1+2*N_LANES, with busy = 0 from that same cycle.
- N_LANES = 8: sweep takes 16 cycles, far below one frame (~416k cycles).
- A frame_tick coincident with done is accepted and starts a new sweep the next cycle.
- car_x changes only during UPDATE cycles, during restart, or during reset.

## Structure
- Shared package game_pkg: H_RES, LANE_Y0, LANE_H, CAR_W, PLAYER_W, coordinate width (10), and the FSM state encoding.
- One sub-module, lane_step, is natural: combinational next-x from (x, dir, STEP, H_RES), plus the period compare. The engine time-multiplexes a single instance across lanes.

## Test plan
- Reset, then read car_x: lane i = i*80 (lane 7 = 560); hit/busy/done/overrun all 0.
- Lane 1 (right, period 2, level 0) starting at x = 638: frame_tick pulses -> x goes 638, 638→0 on the 2nd tick, then 2 on the 4th tick. Wrap is exact.
- Lane 0 (left, period 1) at x = 1, STEP 2 -> 639 after one tick. level = 7 -> every lane steps every frame.
- Player at y = LANE_Y0+3*LANE_H with player_x = car_x_3 + 31 -> hit = 1 at t+17. With player_x = car_x_3 + 32 -> hit = 0. Car at 630, player at 10 -> hit = 1 (wrap overlap).
- frame_tick at t and t+5 -> second tick ignored, overrun = 1. Then restart -> overrun = 0 and positions reloaded.
- restart at t+4 mid-sweep -> no done pulse, positions equal reset values; enable = 0 for 3 ticks -> car_x unchanged, but hit still updates.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game geometry, coordinate width and obstacle-engine FSM encoding.
package game_pkg;
  localparam int COORD_W  = 10;
  localparam int H_RES    = 640;
  localparam int CAR_W    = 32;
  localparam int PLAYER_W = 32;
  localparam int LANE_Y0  = 64;
  localparam int LANE_H   = 32;

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_COLLIDE} eng_state_e;

  function automatic logic [COORD_W-1:0] reset_x(input int lane, input int spacing, input int hres);
    return COORD_W'((lane * spacing) % hres);
  endfunction
endpackage

// File: rtl/obstacle_engine_lane_step.sv
// Combinational per-lane step: wrapped next x and frame-counter/period compare.
module lane_step
  import game_pkg::*;
#(
  parameter int H_RES = game_pkg::H_RES,
  parameter int STEP  = 2
) (
  input  logic [COORD_W-1:0] x,
  input  logic               dir,
  input  logic [3:0]         cnt,
  input  logic [3:0]         base_per,
  input  logic [2:0]         level,
  output logic [COORD_W-1:0] x_next,
  output logic [3:0]         cnt_next,
  output logic               step_due
);
  logic [3:0]       base, per;
  logic [4:0]       cnt_inc;
  logic [COORD_W:0] sum;

  always_comb begin
    base     = (base_per == 4'd0) ? 4'd1 : base_per;
    per      = (base > {1'b0, level}) ? base - {1'b0, level} : 4'd1;
    cnt_inc  = {1'b0, cnt} + 5'd1;
    step_due = cnt_inc >= {1'b0, per};
    cnt_next = step_due ? 4'd0 : cnt_inc[3:0];
    sum      = {1'b0, x} + (COORD_W+1)'(STEP);
    if (dir)
      x_next = (sum >= (COORD_W+1)'(H_RES)) ? COORD_W'(sum - (COORD_W+1)'(H_RES)) : sum[COORD_W-1:0];
    else if (x < COORD_W'(STEP))
      x_next = COORD_W'({1'b0, x} + (COORD_W+1)'(H_RES - STEP));
    else
      x_next = x - COORD_W'(STEP);
  end
endmodule

// File: rtl/obstacle_engine.sv
// Multi-lane car engine: per-frame lane update sweep followed by a player collision sweep.
module obstacle_engine
  import game_pkg::*;
#(
  parameter int          N_LANES   = 8,
  parameter int          H_RES     = game_pkg::H_RES,
  parameter int          CAR_W     = game_pkg::CAR_W,
  parameter int          PLAYER_W  = game_pkg::PLAYER_W,
  parameter int          LANE_Y0   = game_pkg::LANE_Y0,
  parameter int          LANE_H    = game_pkg::LANE_H,
  parameter int          STEP      = 2,
  parameter logic [15:0] DIR_MASK  = 16'b1010_1010,
  parameter logic [63:0] BASE_PER  = 64'h1234_4321,
  parameter int          X_SPACING = 80
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       frame_tick,
  input  logic                       restart,
  input  logic                       enable,
  input  logic [2:0]                 level,
  input  logic [COORD_W-1:0]         player_x,
  input  logic [COORD_W-1:0]         player_y,
  output logic [COORD_W*N_LANES-1:0] car_x,
  output logic                       busy,
  output logic                       done,
  output logic                       hit,
  output logic                       overrun
);
  localparam int IW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  eng_state_e                          state_q, state_d;
  logic [IW-1:0]                       idx_q, idx_d;
  logic [N_LANES-1:0][COORD_W-1:0]     car_x_q, car_x_d, car_x_rst;
  logic [N_LANES-1:0][3:0]             cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, hit_q, hit_d, overrun_q, overrun_d, acc_q, acc_d;

  for (genvar i = 0; i < N_LANES; i++) begin : g_rst
    assign car_x_rst[i] = reset_x(i, X_SPACING, H_RES);
  end

  logic [COORD_W-1:0] step_x;
  logic [3:0]         step_cnt;
  logic               step_due;

  // One step unit shared by all lanes; idx_q selects the lane being updated.
  lane_step #(.H_RES(H_RES), .STEP(STEP)) u_step (
    .x(car_x_q[idx_q]), .dir(DIR_MASK[idx_q]), .cnt(cnt_q[idx_q]),
    .base_per(BASE_PER[4*idx_q +: 4]), .level(level),
    .x_next(step_x), .cnt_next(step_cnt), .step_due(step_due)
  );

  logic [COORD_W:0] lane_y, d_pc, d_cp;
  logic             lane_hit;

  always_comb begin
    lane_y = (COORD_W+1)'(LANE_Y0) + (COORD_W+1)'(LANE_H) * (COORD_W+1)'(idx_q);
    d_pc   = {1'b0, player_x} - {1'b0, car_x_q[idx_q]};
    if (player_x < car_x_q[idx_q]) d_pc = d_pc + (COORD_W+1)'(H_RES);
    d_cp   = {1'b0, car_x_q[idx_q]} - {1'b0, player_x};
    if (car_x_q[idx_q] < player_x) d_cp = d_cp + (COORD_W+1)'(H_RES);
    lane_hit = ({1'b0, player_y} == lane_y) &&
               ((d_pc < (COORD_W+1)'(CAR_W)) || (d_cp < (COORD_W+1)'(PLAYER_W)));
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    car_x_d   = car_x_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hit_d     = hit_q;
    overrun_d = overrun_q;
    acc_d     = acc_q;
    if (restart) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      car_x_d   = car_x_rst;
      cnt_d     = '0;
      busy_d    = 1'b0;
      overrun_d = 1'b0;
      acc_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (frame_tick) begin
          state_d = S_UPDATE;
          idx_d   = '0;
          busy_d  = 1'b1;
          acc_d   = 1'b0;
        end
        S_UPDATE: begin
          if (frame_tick) overrun_d = 1'b1;
          if (enable) begin
            cnt_d[idx_q] = step_cnt;
            if (step_due) car_x_d[idx_q] = step_x;
          end
          if (idx_q == IW'(N_LANES-1)) begin
            state_d = S_COLLIDE;
            idx_d   = '0;
          end else idx_d = idx_q + 1'b1;
        end
        S_COLLIDE: begin
          if (frame_tick) overrun_d = 1'b1;
          acc_d = acc_q | lane_hit;
          if (idx_q == IW'(N_LANES-1)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            hit_d   = acc_q | lane_hit;
          end else idx_d = idx_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      car_x_q   <= car_x_rst;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      overrun_q <= 1'b0;
      acc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      car_x_q   <= car_x_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hit_q     <= hit_d;
      overrun_q <= overrun_d;
      acc_q     <= acc_d;
    end
  end

  assign car_x   = car_x_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign hit     = hit_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_obstacle_engine.sv
// Bench for obstacle_engine: lane model + scoreboard, vector table and directed corner sequences.
module tb_obstacle_engine;
  localparam int N = 8;
  localparam logic [7:0]  DIRM = 8'hAA;
  localparam logic [31:0] BPER = 32'h1234_4321;

  logic        clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, restart = 1'b0, enable = 1'b1;
  logic [2:0]  level = '0;
  logic [9:0]  player_x = '0, player_y = '0;
  logic [79:0] car_x;
  logic        busy, done, hit, overrun;

  obstacle_engine dut (
    .CLK(clk), .RST_N(rst_n), .frame_tick(frame_tick), .restart(restart), .enable(enable),
    .level(level), .player_x(player_x), .player_y(player_y), .car_x(car_x),
    .busy(busy), .done(done), .hit(hit), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int m_x[N];
  int m_cnt[N];
  typedef struct { logic [79:0] x; logic h; } exp_t;
  exp_t sb[$];

  typedef struct { bit en; int lvl; int lane; int off; bit exp_h; } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_x[i] = (i * 80) % 640; m_cnt[i] = 0; end
  endtask

  function automatic logic [79:0] model_vec();
    logic [79:0] v;
    for (int i = 0; i < N; i++) v[10*i +: 10] = 10'(m_x[i]);
    return v;
  endfunction

  task automatic model_frame(input bit en, input int lvl);
    int b, p;
    logic [31:0] bp;
    bp = BPER;
    for (int i = 0; i < N; i++) begin
      b = int'(bp[4*i +: 4]);
      if (b == 0) b = 1;
      p = (b > lvl) ? b - lvl : 1;
      if (en) begin
        if (m_cnt[i] + 1 >= p) begin
          m_cnt[i] = 0;
          if (DIRM[i]) m_x[i] = (m_x[i] + 2) % 640;
          else         m_x[i] = (m_x[i] + 640 - 2) % 640;
        end else m_cnt[i]++;
      end
    end
  endtask

  function automatic bit model_hit(input int px, input int py);
    for (int i = 0; i < N; i++)
      if (py == 64 + 32 * i)
        if ((px - m_x[i] + 640) % 640 < 32 || (m_x[i] - px + 640) % 640 < 32) return 1'b1;
    return 1'b0;
  endfunction

  // Called at a negedge; leaves the bench at the negedge of cycle t+1.
  task automatic start_frame(input bit en, input int lvl, input int lane, input int off);
    exp_t e;
    int px, py;
    model_frame(en, lvl);
    if (lane >= 0) begin px = (m_x[lane] + off + 1280) % 640; py = 64 + 32 * lane; end
    else begin px = 0; py = 5; end
    enable = en; level = 3'(lvl); player_x = 10'(px); player_y = 10'(py); frame_tick = 1'b1;
    e.x = model_vec(); e.h = model_hit(px, py);
    sb.push_back(e);
    @(negedge clk);
    frame_tick = 1'b0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic finish_frame(input int n0);
    int n;
    exp_t e;
    n = n0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    e = sb.pop_front();
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done after %0d cycles expected one at 17", n);
      return;
    end
    chk("latency", n, 17);
    chk("car_x", car_x, e.x);
    chk("hit", hit, e.h);
    chk("busy_fall", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1);
  end

  initial begin
    logic [79:0] prev;
    logic        hv;
    int          lane, off;
    tbl = '{'{1, 0, 3, 31, 1}, '{1, 0, 3, 32, 0}, '{1, 0, 3, -31, 1}, '{1, 0, 3, -32, 0},
            '{1, 0, -1, 0, 0}, '{0, 0, 3, 0, 1}, '{0, 0, 5, 40, 0}, '{0, 0, 0, -10, 1},
            '{1, 7, 6, 16, 1}, '{1, 3, 2, -33, 0}};
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_car_x", car_x, model_vec());
    chk("reset_lane7", car_x[79:70], 10'd560);
    chk("reset_flags", {hit, busy, done, overrun}, 4'b0000);

    foreach (tbl[k]) begin
      prev = car_x;
      start_frame(tbl[k].en, tbl[k].lvl, tbl[k].lane, tbl[k].off);
      finish_frame(1);
      chk("tbl_hit", hit, tbl[k].exp_h);
      if (!tbl[k].en) chk("frozen", car_x, prev);
      @(negedge clk);
    end

    // Back-to-back: frame_tick in the done cycle must start a new sweep.
    start_frame(1, 7, 1, 0);
    finish_frame(1);
    start_frame(1, 7, 4, 5);
    finish_frame(1);
    chk("no_overrun_on_done", overrun, 0);
    @(negedge clk);

    for (int f = 0; f < 340; f++) begin
      lane = $urandom_range(0, 8);
      if (lane == 8) lane = -1;
      off = int'($urandom_range(0, 80)) - 40;
      if (f < 300) begin
        if (m_x[1] >= 616) begin
          start_frame(1, 7, 1, 20);
          finish_frame(1);
          chk("wrap_hit", hit, 1);
        end else begin
          start_frame(1, 7, lane, off);
          finish_frame(1);
        end
      end else begin
        start_frame(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), lane, off);
        finish_frame(1);
      end
      @(negedge clk);
    end

    // Second tick at t+5 is ignored and flags overrun.
    start_frame(1, 0, 2, 0);
    repeat (4) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    finish_frame(6);
    chk("overrun_set", overrun, 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_reset();
    chk("overrun_clr", overrun, 0);
    chk("restart_car_x", car_x, model_vec());

    // Restart mid-sweep: no done, positions reloaded, hit held.
    hv = hit;
    enable = 1'b1; level = 3'd7; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done) begin n_cmp++; n_bad++; $display("FAIL abort_done: got done 1 expected 0"); break; end
      @(negedge clk);
    end
    chk("abort_car_x", car_x, model_vec());
    chk("abort_hit_held", hit, hv);
    chk("abort_busy", busy, 0);

    start_frame(1, 0, 0, 0);
    finish_frame(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
